// File: rtl/rpi_bus_tx_if.sv
// Host-side transmit handshake for rpi_bus_tx: byte queueing, occupancy and
// the sticky underrun flag.
interface rpi_bus_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [CW-1:0] tx_count;
    logic          underrun;
    logic          underrun_clr;

    modport master (
        output tx_data, tx_valid, underrun_clr,
        input  tx_ready, tx_count, underrun
    );

    modport slave (
        input  tx_data, tx_valid, underrun_clr,
        output tx_ready, tx_count, underrun
    );
endinterface

// File: rtl/rpi_bus_tx.sv
// Raspberry Pi parallel-bus read path: queues host bytes in a FIFO and presents
// them on bus_data, advancing one byte per synchronized bus_clk rising edge.
module rpi_bus_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_100mhz,
    input  logic        reset_n,
    input  logic        bus_clk,
    input  logic        bus_rnw,
    inout  wire  [7:0]  bus_data,
    output logic        bus_oe,
    rpi_bus_tx_if.slave tx_if
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_DRIVE} state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync, r_rnw_sync, r_sync_vld;
    logic                   r_clk_s_d, r_armed, r_strobe;
    logic                   w_clk_s, w_rnw_s, w_edge;
    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_rd, r_wr, w_rd_nxt;
    logic [CW-1:0]          r_count;
    logic                   r_rdy_en, r_underrun;
    logic [7:0]             r_out, w_out_nxt;
    logic                   w_push, w_pop, w_load, w_set_udr, w_empty;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_rnw_s  = r_rnw_sync[SYNC_STAGES-1];
    // The arm flag ignores the reset zeros still flushing through the chain,
    // so a bus_clk held high across reset is not taken as a rising edge.
    assign w_edge   = w_clk_s && !r_clk_s_d && r_armed;
    assign w_empty  = (r_count == '0);
    assign w_rd_nxt = r_rd + AW'(1);

    assign tx_if.tx_ready = r_rdy_en && (r_count < DEPTH_C);
    assign tx_if.tx_count = r_count;
    assign tx_if.underrun = r_underrun;
    assign w_push         = tx_if.tx_valid && tx_if.tx_ready;

    assign bus_oe   = (r_state == S_DRIVE) && w_rnw_s;
    assign bus_data = bus_oe ? r_out : 8'bz;

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            r_clk_sync <= '0;
            r_rnw_sync <= '0;
            r_sync_vld <= '0;
            r_clk_s_d  <= 1'b0;
            r_armed    <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus_clk};
            r_rnw_sync <= {r_rnw_sync[SYNC_STAGES-2:0], bus_rnw};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_clk_s_d  <= w_clk_s;
            r_strobe   <= w_edge;
            if (r_sync_vld[SYNC_STAGES-1] && !w_clk_s)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_out_nxt   = r_out;
        w_pop       = 1'b0;
        w_set_udr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rnw_s)
                    w_state_nxt = S_TURN;
            end
            S_TURN: begin
                w_load      = 1'b1;
                w_out_nxt   = w_empty ? 8'h00 : r_mem[r_rd];
                w_state_nxt = w_rnw_s ? S_DRIVE : S_IDLE;
            end
            S_DRIVE: begin
                if (!w_rnw_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_strobe) begin
                    w_load = 1'b1;
                    if (w_empty) begin
                        w_set_udr = 1'b1;
                        w_out_nxt = 8'h00;
                    end else begin
                        w_pop = 1'b1;
                        // With one entry left, a same-cycle push becomes the next head.
                        if (r_count > CW'(1))
                            w_out_nxt = r_mem[w_rd_nxt];
                        else if (w_push)
                            w_out_nxt = tx_if.tx_data;
                        else
                            w_out_nxt = 8'h00;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (w_push)
            r_mem[r_wr] <= tx_if.tx_data;
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_rdy_en   <= 1'b0;
            r_underrun <= 1'b0;
            r_out      <= 8'h00;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= w_rd_nxt;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_load)
                r_out <= w_out_nxt;
            if (w_set_udr)
                r_underrun <= 1'b1;
            else if (tx_if.underrun_clr)
                r_underrun <= 1'b0;
        end
    end
endmodule
